// File: rtl/lc3_useq.sv
// LC-3 microsequencer: next control-store state from J/COND/IRD, BEN latch, priority interrupt arbiter.
// Optional memory-ready timeout is built when USEQ_TMO_EN is defined.
module lc3_useq #(
   parameter int SW        = 6,
   parameter int CW        = 42,
   parameter int NIRQ      = 4,
   parameter int RST_STATE = 51,
   parameter int ERR_STATE = 48,
   parameter int TMO       = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SW-1:0]     uc_j,
   input  logic [2:0]        uc_cond,
   input  logic              uc_ird,
   input  logic [CW-1:0]     uc_ctrl,
   input  logic              ld_ben,
   input  logic [15:0]       ir,
   input  logic              n,
   input  logic              z,
   input  logic              p,
   input  logic              ready,
   input  logic              acv,
   input  logic              psr_15,
   input  logic [2:0]        psr_pri,
   input  logic [NIRQ-1:0]   irq_req,
   input  logic [3*NIRQ-1:0] irq_pri,
   input  logic [8*NIRQ-1:0] irq_vec,
   output logic [SW-1:0]     state,
   output logic [CW-1:0]     ctrl_sig,
   output logic [7:0]        int_vec,
   output logic [2:0]        int_pri,
   output logic [NIRQ-1:0]   irq_ack,
   output logic              bus_err
);

   localparam logic [2:0] C_MEM_RDY = 3'd1;
   localparam logic [2:0] C_BRANCH  = 3'd2;
   localparam logic [2:0] C_ADDR    = 3'd3;
   localparam logic [2:0] C_PRIV    = 3'd4;
   localparam logic [2:0] C_INT     = 3'd5;
   localparam logic [2:0] C_ACV     = 3'd6;

   logic [SW-1:0]   state_q, state_d;
   logic            ben_q, ben_d;
   logic [7:0]      int_vec_q, int_vec_d;
   logic [2:0]      int_pri_q, int_pri_d;
   logic [NIRQ-1:0] irq_ack_q, irq_ack_d;

   logic            int_pend;
   logic [2:0]      win_pri;
   logic [7:0]      win_vec;
   logic [NIRQ-1:0] win_oh;
   logic            accept;
   logic            tmo_exp;
   logic [SW-1:0]   j_mod;

   logic unused_ir;
   assign unused_ir = &{1'b0, ir[8:0]};

   // Ascending scan with strict '>' keeps the lowest index on equal priority.
   always_comb begin
      int_pend = 1'b0;
      win_pri  = psr_pri;
      win_vec  = '0;
      win_oh   = '0;
      for (int k = 0; k < NIRQ; k++) begin
         if (irq_req[k] && (irq_pri[3*k +: 3] > win_pri)) begin
            int_pend  = 1'b1;
            win_pri   = irq_pri[3*k +: 3];
            win_vec   = irq_vec[8*k +: 8];
            win_oh    = '0;
            win_oh[k] = 1'b1;
         end
      end
   end

   assign accept = !uc_ird && (uc_cond == C_INT) && int_pend;

   always_comb begin
      j_mod = uc_j;
      case (uc_cond)
         C_MEM_RDY: j_mod[1] = uc_j[1] | ready;
         C_BRANCH:  j_mod[2] = uc_j[2] | ben_q;
         C_ADDR:    j_mod[0] = uc_j[0] | ir[11];
         C_PRIV:    j_mod[3] = uc_j[3] | psr_15;
         C_INT:     j_mod[4] = uc_j[4] | int_pend;
         C_ACV:     j_mod[5] = uc_j[5] | acv;
         default:   j_mod    = uc_j;
      endcase
   end

   always_comb begin
      state_d   = uc_ird ? {{(SW-4){1'b0}}, ir[15:12]} : j_mod;
      if (tmo_exp) state_d = SW'(ERR_STATE);
      ben_d     = ld_ben ? ((ir[11] & n) | (ir[10] & z) | (ir[9] & p)) : ben_q;
      int_vec_d = accept ? win_vec : int_vec_q;
      int_pri_d = accept ? win_pri : int_pri_q;
      irq_ack_d = accept ? win_oh : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SW'(RST_STATE);
         ben_q     <= 1'b0;
         int_vec_q <= '0;
         int_pri_q <= '0;
         irq_ack_q <= '0;
      end else begin
         state_q   <= state_d;
         ben_q     <= ben_d;
         int_vec_q <= int_vec_d;
         int_pri_q <= int_pri_d;
         irq_ack_q <= irq_ack_d;
      end
   end

`ifdef USEQ_TMO_EN
   localparam int TW = (TMO > 2) ? $clog2(TMO) : 1;

   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          bus_err_q, bus_err_d;
   logic          tmo_wait;

   // Ready on the expiry cycle drops tmo_wait, so the normal branch wins.
   always_comb begin
      tmo_wait  = !uc_ird && (uc_cond == C_MEM_RDY) && !ready;
      tmo_exp   = tmo_wait && (tcnt_q == TW'(TMO - 1));
      tcnt_d    = (tmo_wait && !tmo_exp) ? tcnt_q + 1'b1 : '0;
      bus_err_d = tmo_exp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt_q    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         tcnt_q    <= tcnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign bus_err = bus_err_q;
`else
   assign tmo_exp = 1'b0;
   assign bus_err = 1'b0;
`endif

   assign state    = state_q;
   assign ctrl_sig = uc_ctrl;
   assign int_vec  = int_vec_q;
   assign int_pri  = int_pri_q;
   assign irq_ack  = irq_ack_q;

endmodule

// File: doc/lc3_useq.md
# lc3_useq

Parametrised microsequencer for the LC-3 core of NES_SOC. It holds the current control-store state and computes the next state from the microinstruction's J field, COND field and IRD bit, using branch enable, ready, privilege, interrupt-pending and access-violation qualifiers. It adds a multi-channel priority interrupt arbiter and an optional memory-ready timeout. It sits between the external control-store ROM and the datapath. `state` addresses the ROM, and the ROM word returns through `uc_ctrl` and is forwarded on `ctrl_sig`.

## Interface
Parameters:
- SW, 6, state/J field width (≥6)
- CW, 42, control word width
- NIRQ, 4, interrupt request channels (1..8)
- RST_STATE, 51, state entered on reset
- ERR_STATE, 48, state forced on ready timeout
- TMO, 64, ready-timeout cycles (≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- uc_j  in  SW  J field of current microword
- uc_cond  in  3  COND field of current microword: 0 uncond, 1 mem_rdy, 2 branch, 3 addr_mode, 4 priv, 5 int, 6 acv, 7 reserved (acts as 0)
- uc_ird  in  1  IRD bit of current microword
- uc_ctrl  in  CW  remaining control bits of current microword
- ld_ben  in  1  latch BEN this cycle
- ir  in  16  instruction register
- n, z, p  in  1 each  condition codes
- ready  in  1  memory ready
- acv  in  1  access violation
- psr_15  in  1  privilege (1 = user)
- psr_pri  in  3  current PSR priority
- irq_req  in  NIRQ  interrupt requests, level
- irq_pri  in  3*NIRQ  per-channel priority, channel k at [3k+2:3k]
- irq_vec  in  8*NIRQ  per-channel vector, channel k at [8k+7:8k]
- state  out  SW  current state / ROM address
- ctrl_sig  out  CW  equal to uc_ctrl (combinational)
- int_vec  out  8  latched vector of accepted interrupt
- int_pri  out  3  latched priority of accepted interrupt
- irq_ack  out  NIRQ  one-hot, one-cycle acknowledge
- bus_err  out  1  one-cycle timeout pulse

## Operation
- BEN register: on ld_ben, ben <= (ir[11]&n)|(ir[10]&z)|(ir[9]&p).
- Arbiter (combinational): winner is the channel with irq_req=1 and irq_pri > psr_pri, with the highest irq_pri. Ties go to the lowest index. int_pend = winner exists.
- Next-state rules:
  - uc_ird=1: next = zero-extended ir[15:12]. COND is ignored.
  - Otherwise next = uc_j, with one bit ORed according to COND: mem_rdy sets j[1]|=ready; branch sets j[2]|=ben; addr_mode sets j[0]|=ir[11]; priv sets j[3]|=psr_15; int sets j[4]|=int_pend; acv sets j[5]|=acv.
- Interrupt accept: when uc_cond=int and int_pend=1 on a clock edge, all of the following happen on that edge:
  - int_vec and int_pri load the winner's values.
  - irq_ack pulses the winner's bit for one cycle.
  - The sequencer branches.
  - No request change is sampled mid-cycle.
- Timeout (with macro): counter tcnt increments while uc_cond=mem_rdy and ready=0 and uc_ird=0. It clears otherwise. When tcnt = TMO-1 and the wait condition still holds:
  - next state = ERR_STATE, overriding the J/COND result;
  - bus_err pulses for one cycle;
  - tcnt clears.
- ready=1 on the expiry cycle wins: normal branch, no bus_err.

## Timing
- Reset values: state=RST_STATE, ben=0, int_vec=0, int_pri=0, irq_ack=0, bus_err=0, tcnt=0. ctrl_sig follows uc_ctrl.
- Reset assertion mid-operation returns state to RST_STATE asynchronously and drops pending acks and pulses.
- state updates every rising edge, with one-cycle latency from qualifiers to state.
- The ROM is combinational, so uc_* must be valid in the same cycle as state.
- irq_ack and bus_err are registered and appear the cycle after the accepting or expiring edge, aligned with the new state.
- A request dropped before the accept edge is not acknowledged. A new request during an ack cycle is arbitrated normally.
- ld_ben and the branch test in the same cycle: the branch uses the old ben.

## Configuration
- USEQ_TMO_EN defined: the timeout counter, ERR_STATE override and bus_err are active.
- USEQ_TMO_EN undefined: no counter is built. bus_err is tied to 0, and mem_rdy waits indefinitely. TMO and ERR_STATE are unused.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0, release it, and drive uc_j=18 with uc_cond=0.
  - Response: state=51 during reset, 18 after the first edge, and all outputs 0.
- Decode:
  - Stimulus: uc_ird=1 with ir=16'h6xxx (LDR).
  - Response: next state=6. COND is ignored.
- Branch:
  - Stimulus: ir[11:9]=3'b010, z=1, ld_ben pulsed, then uc_j=18 with uc_cond=2.
  - Response: state=22. Repeating with z=0 gives 18.
- Ready wait:
  - Stimulus: uc_j=28, uc_cond=1, ready=0 for 5 cycles, then ready=1.
  - Response: state stays 28 for 5 cycles, then becomes 30.
- Interrupt:
  - Stimulus: psr_pri=2; ch1 requests pri 4 with vec 8'h81; ch3 requests pri 4 with vec 8'h83; ch0 requests pri 1. Then uc_j=33 with uc_cond=5.
  - Response: state=49, int_vec=8'h81, int_pri=4, and irq_ack=4'b0010 for one cycle.
- Timeout (macro on, TMO=8):
  - Stimulus: uc_cond=1 and ready=0 held.
  - Response: after 8 cycles in the wait, state=48 and bus_err=1 for one cycle.
  - Variant: with ready=1 on the 8th cycle, there is a normal exit and no bus_err.
